pipeline_hazard_ctrl: RTL

Central stall/flush/interrupt sequencer for the five-stage MIPS pipeline. It watches pre-decoded fields from the D, E and M stages and generates the freeze, bubble and clear strobes consumed by the PC, the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also owns the mult/div busy counter and the interrupt-entry state machine. Its `int_clr` output drives the `int_clr` inputs of the EX/MEM and MEM/WB registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_md_busy_counter.sv | 53 +++++
 rtl/pipeline_hazard_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_MD = 2'd1,
        ST_ENTER   = 2'd2,
        ST_MASK    = 2'd3
    } int_state_t;

    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Purpose  : Pre-decoded stage fields in, stall/flush/interrupt strobes out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;

    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic       use_rs_D;
    logic       use_rt_D;
    logic       md_use_D;
    logic       load_E;
    logic [4:0] dst_E;
    logic       md_start_E;
    logic       md_div_E;
    logic       int_req;

    logic       stall_FD;
    logic       flush_E;
    logic       int_clr;
    logic       epc_capture;
    logic       redirect;
    logic       md_busy;

    // Pipeline side: drives decode fields, consumes strobes.
    modport master (
        output rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        output load_E, dst_E, md_start_E, md_div_E, int_req,
        input  stall_FD, flush_E, int_clr, epc_capture, redirect, md_busy
    );

    // Controller side.
    modport slave (
        input  rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        input  load_E, dst_E, md_start_E, md_div_E, int_req,
        output stall_FD, flush_E, int_clr, epc_capture, redirect, md_busy
    );

endinterface : pipeline_hazard_ctrl_if

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_md_busy_counter.sv
// ============================================================================
// Module   : md_busy_counter
// Purpose  : Mult/div occupancy countdown; flags busy and the final cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic start_i,
    input  wire logic div_i,
    output logic      busy_o,
    output logic      last_o
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A start while the unit is still counting is dropped; upstream stalls prevent it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == '0) begin
            if (start_i) begin
                cnt_d = div_i ? DIV_LD : MULT_LD;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == CNT_ONE);

endmodule : md_busy_counter

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush/interrupt-entry sequencer for the five-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    pipeline_hazard_ctrl_if.slave   hz
);

    int_state_t state_q;
    logic       w_busy;
    logic       w_last;
    logic       w_lu;
    logic       w_mdh;
    logic       w_enter;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .start_i (hz.md_start_E),
        .div_i   (hz.md_div_E),
        .busy_o  (w_busy),
        .last_o  (w_last)
    );

    assign w_lu  = hz.load_E && (hz.dst_E != REG_ZERO) &&
                   ((hz.use_rs_D && (hz.rs_D == hz.dst_E)) ||
                    (hz.use_rt_D && (hz.rt_D == hz.dst_E)));
    assign w_mdh = hz.md_use_D && (w_busy || hz.md_start_E);

    // A dropped request wins over a simultaneous drain so each level enters at most once.
    // The idle-and-not-starting escape covers a WAIT_MD entered on the counter's last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hz.int_req) begin
                        state_q <= (w_busy || hz.md_start_E) ? ST_WAIT_MD : ST_ENTER;
                    end
                end
                ST_WAIT_MD: begin
                    if (!hz.int_req) begin
                        state_q <= ST_IDLE;
                    end else if (w_last || (!w_busy && !hz.md_start_E)) begin
                        state_q <= ST_ENTER;
                    end
                end
                ST_ENTER: state_q <= ST_MASK;
                ST_MASK: begin
                    if (!hz.int_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_enter = (state_q == ST_ENTER) && !reset;

    assign hz.int_clr     = w_enter;
    assign hz.epc_capture = w_enter;
    assign hz.redirect    = w_enter;
    assign hz.flush_E     = !reset && (w_enter || w_lu || w_mdh);
    assign hz.stall_FD    = !reset && !w_enter && (w_lu || w_mdh);
    assign hz.md_busy     = !reset && w_busy;

endmodule : pipeline_hazard_ctrl

`default_nettype wire
